// File: rtl/udp_rx_mux.sv
// udp_rx_mux: MII Ethernet/IPv4/UDP receiver steering payload to per-port channels, with FCS check, ARP capture and drop count
module udp_rx_mux #(
    parameter logic [47:0] LOCAL_MAC = 48'h000A3501FEC0,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A80002,
    parameter logic [15:0] PORT_BASE = 16'd8080,
    parameter int          NUM_PORTS = 4,
    parameter bit          CHECK_FCS = 1'b1
) (
    input  logic        r_clk,
    input  logic        rst_n,
    input  logic        r_dv,
    input  logic [3:0]  datain,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic [1:0]  rx_chan,
    output logic [15:0] rx_len,
    output logic        stat_valid,
    output logic        stat_ok,
    output logic        arp_req,
    output logic [47:0] arp_mac,
    output logic [31:0] arp_ip,
    output logic [15:0] cnt_drop
);
    typedef enum logic [3:0] {IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER, ARP, DISCARD} state_t;
    state_t      state, state_n;
    logic        phase, is_arp, bd, eof, fcs_good, drop;
    logic [3:0]  lo;
    logic [7:0]  b;
    logic [15:0] idx, plen, w16, port_off;
    logic [31:0] crc, crc_n, residue, w32, sh_ip;
    logic [39:0] sh;
    logic [47:0] w48, sh_mac;
    logic [1:0]  chan;

    // header fields are picked off the byte history as their last byte arrives
    always_comb begin
        b        = {datain, lo};
        bd       = r_dv && phase && (state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER, ARP});
        eof      = !r_dv && state != IDLE;
        w16      = {sh[7:0], b};
        w32      = {sh[23:0], b};
        w48      = {sh, b};
        port_off = w16 - PORT_BASE;
    end

    always_comb begin
        crc_n = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) crc_n = crc_n[0] ? (crc_n >> 1) ^ 32'hEDB88320 : crc_n >> 1;
        residue = '0;
        for (int i = 0; i < 32; i++) residue[i] = crc[31-i];
        fcs_good = !CHECK_FCS || residue == 32'hC704DD7B;
    end

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (eof) state_n = IDLE;
        else case (state)
            IDLE:     if (r_dv) state_n = PREAMBLE;
            PREAMBLE: state_n = datain == 4'hD ? ETH_HDR : datain == 4'h5 ? PREAMBLE : DISCARD;
            ETH_HDR:  if (bd) begin
                if (idx == 16'd5 && w48 != LOCAL_MAC && w48 != '1) state_n = DISCARD;
                if (idx == 16'd13) state_n = w16 == 16'h0800 ? IP_HDR : w16 == 16'h0806 ? ARP : DISCARD;
            end
            IP_HDR:   if (bd) begin
                if ((idx == 16'd0 && b != 8'h45) || (idx == 16'd7 && w16[13:0] != 14'd0) ||
                    (idx == 16'd9 && b != 8'd17) || (idx == 16'd19 && w32 != LOCAL_IP)) state_n = DISCARD;
                else if (idx == 16'd19) state_n = UDP_HDR;
            end
            UDP_HDR:  if (bd) begin
                if ((idx == 16'd3 && port_off >= 16'(NUM_PORTS)) || (idx == 16'd5 && w16 < 16'd8)) state_n = DISCARD;
                else if (idx == 16'd7) state_n = plen == 16'd0 ? TRAILER : PAYLOAD;
            end
            PAYLOAD:  if (bd && idx == plen - 16'd1) state_n = TRAILER;
            ARP:      if (bd) begin
                if ((idx == 16'd1 && w16 != 16'h0001) || (idx == 16'd3 && w16 != 16'h0800) ||
                    (idx == 16'd7 && w16 != 16'h0001) || (idx == 16'd27 && w32 != LOCAL_IP)) state_n = DISCARD;
                else if (idx == 16'd27) state_n = TRAILER;
            end
            default: ;
        endcase
    end

    // end-of-frame status is decided in the first r_dv-low cycle itself
    always_comb begin
        stat_valid = eof && !is_arp && (state == PAYLOAD || state == TRAILER);
        stat_ok    = stat_valid && state == TRAILER && fcs_good;
        arp_req    = eof && is_arp && state == TRAILER && fcs_good;
        drop       = eof && ((state inside {ETH_HDR, IP_HDR, UDP_HDR, ARP, DISCARD}) || (stat_valid && !stat_ok) ||
                             (is_arp && state == TRAILER && !fcs_good));
    end

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 1'b0;
            lo       <= '0;
            idx      <= '0;
            sh       <= '0;
            crc      <= '1;
            is_arp   <= 1'b0;
            chan     <= '0;
            plen     <= '0;
            sh_mac   <= '0;
            sh_ip    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_sop   <= 1'b0;
            rx_eop   <= 1'b0;
            rx_chan  <= '0;
            rx_len   <= '0;
            arp_mac  <= '0;
            arp_ip   <= '0;
            cnt_drop <= '0;
        end else begin
            phase    <= r_dv && !(state inside {IDLE, PREAMBLE}) ? !phase : 1'b0;
            rx_valid <= 1'b0;
            rx_sop   <= 1'b0;
            rx_eop   <= 1'b0;
            if (r_dv && !phase) lo <= datain;
            idx <= state_n != state ? 16'd0 : bd ? idx + 16'd1 : idx;
            if (bd) sh <= {sh[31:0], b};
            crc <= state == PREAMBLE ? '1 : bd ? crc_n : crc;
            if (state == PREAMBLE) is_arp <= 1'b0;
            else if (state_n == ARP) is_arp <= 1'b1;
            if (state == UDP_HDR && bd && idx == 16'd3) chan <= port_off[1:0];
            if (state == UDP_HDR && bd && idx == 16'd5) plen <= w16 - 16'd8;
            if (state == ARP && bd && idx == 16'd13) sh_mac <= w48;
            if (state == ARP && bd && idx == 16'd17) sh_ip <= w32;
            if (state == PAYLOAD && bd) begin
                rx_valid <= 1'b1;
                rx_data  <= b;
                rx_sop   <= idx == 16'd0;
                rx_eop   <= idx == plen - 16'd1;
                if (idx == 16'd0) begin
                    rx_chan <= chan;
                    rx_len  <= plen;
                end
            end
            if (arp_req) begin
                arp_mac <= sh_mac;
                arp_ip  <= sh_ip;
            end
            if (drop && cnt_drop != 16'hFFFF) cnt_drop <= cnt_drop + 16'd1;
        end
    end
endmodule

// File: tb/tb_udp_rx_mux.sv
// tb_udp_rx_mux: directed and randomized frames checked against a field-level model of the receiver
module tb_udp_rx_mux;
    localparam logic [47:0] MAC = 48'h000A3501FEC0;
    localparam logic [31:0] IP  = 32'hC0A80002;

    logic        r_clk = 1'b0, rst_n = 1'b1, r_dv = 1'b0;
    logic [3:0]  datain = 4'h0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sop, rx_eop, stat_valid, stat_ok, arp_req;
    logic [1:0]  rx_chan;
    logic [15:0] rx_len, cnt_drop;
    logic [47:0] arp_mac;
    logic [31:0] arp_ip;

    int checks = 0, errors = 0, cyc = 0, exp_drop = 0, arp_n = 0, arp_first = 0;
    logic [47:0] exp_amac = '0;
    logic [31:0] exp_aip = '0;
    logic dv_prev = 1'b0;

    typedef struct {logic [7:0] d; logic sop; logic eop; logic [1:0] ch; logic [15:0] len; int t;} beat_t;
    typedef struct {logic [47:0] dmac; logic [15:0] etype; logic [7:0] vihl; logic [15:0] frag;
                    logic [7:0] proto; logic [31:0] dip; logic [15:0] dport; int plen; bit bad;} udp_t;
    beat_t      got[$];
    logic       st_q[$];
    logic [7:0] frm[$], pay[$];

    udp_rx_mux dut (
        .r_clk(r_clk), .rst_n(rst_n), .r_dv(r_dv), .datain(datain),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_chan(rx_chan), .rx_len(rx_len), .stat_valid(stat_valid), .stat_ok(stat_ok),
        .arp_req(arp_req), .arp_mac(arp_mac), .arp_ip(arp_ip), .cnt_drop(cnt_drop)
    );

    always #20 r_clk = ~r_clk;

    always @(negedge r_clk) begin
        cyc++;
        if (rx_valid) got.push_back('{d: rx_data, sop: rx_sop, eop: rx_eop, ch: rx_chan, len: rx_len, t: cyc});
        if (stat_valid) st_q.push_back(stat_ok);
        if (arp_req) begin
            arp_n++;
            if (!r_dv && dv_prev) arp_first++;
        end
        dv_prev = r_dv;
    end

    initial begin
        #5ms;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ctl"}, 64'({rx_data, rx_valid, rx_sop, rx_eop, rx_chan, rx_len, stat_valid, stat_ok, arp_req}), 64'd0);
        chk({tag, ".arp_mac"}, 64'(arp_mac), 64'd0);
        chk({tag, ".arp_ip"}, 64'(arp_ip), 64'd0);
        chk({tag, ".cnt_drop"}, 64'(cnt_drop), 64'd0);
    endtask

    task automatic put(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
    endtask

    // pad to minimum frame size, then append the FCS as a transmitter would
    task automatic seal(input bit bad);
        logic [31:0] c;
        c = '1;
        while (frm.size() < 60) frm.push_back(8'h00);
        foreach (frm[i]) begin
            c = c ^ {24'd0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
        if (bad) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'hFF;
    endtask

    function automatic udp_t good();
        udp_t u;
        u.dmac = MAC; u.etype = 16'h0800; u.vihl = 8'h45; u.frag = 16'h0000; u.proto = 8'd17;
        u.dip = IP; u.dport = 16'd8082; u.plen = 5; u.bad = 1'b0;
        return u;
    endfunction

    function automatic bit accept(input udp_t u);
        return (u.dmac == MAC || u.dmac == '1) && u.etype == 16'h0800 && u.vihl == 8'h45 &&
               u.frag[13:0] == 14'd0 && u.proto == 8'd17 && u.dip == IP &&
               u.dport >= 16'd8080 && u.dport <= 16'd8083;
    endfunction

    task automatic build_udp(input udp_t u);
        frm.delete();
        put(64'(u.dmac), 6); put(64'h020000000001, 6); put(64'(u.etype), 2);
        put(64'(u.vihl), 1); put(64'h0, 1); put(64'(28 + u.plen), 2); put(64'h0, 2); put(64'(u.frag), 2);
        put(64'd64, 1); put(64'(u.proto), 1); put(64'h0, 2); put(64'hC0A80001, 4); put(64'(u.dip), 4);
        put(64'd1234, 2); put(64'(u.dport), 2); put(64'(8 + u.plen), 2); put(64'h0, 2);
        foreach (pay[i]) frm.push_back(pay[i]);
        seal(u.bad);
    endtask

    task automatic build_arp(input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa, input bit bad);
        frm.delete();
        put(64'hFFFFFFFFFFFF, 6); put(64'(sha), 6); put(64'h0806, 2);
        put(64'h0001, 2); put(64'h0800, 2); put(64'h06, 1); put(64'h04, 1); put(64'h0001, 2);
        put(64'(sha), 6); put(64'(spa), 4); put(64'h0, 6); put(64'(tpa), 4);
        seal(bad);
    endtask

    task automatic nib(input logic [3:0] n);
        @(posedge r_clk); #1;
        r_dv = 1'b1;
        datain = n;
    endtask

    task automatic drive(input int nbytes);
        got.delete(); st_q.delete(); arp_n = 0; arp_first = 0;
        for (int i = 0; i < 15; i++) nib(4'h5);
        nib(4'hD);
        for (int i = 0; i < nbytes; i++) begin
            nib(frm[i][3:0]);
            nib(frm[i][7:4]);
        end
    endtask

    task automatic stop(input int gap);
        @(posedge r_clk); #1;
        r_dv = 1'b0;
        datain = 4'h0;
        repeat (gap) @(posedge r_clk);
        #1;
    endtask

    task automatic rand_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic check_udp(input string tag, input udp_t u, input int sent, input bit complete);
        bit acc, ok;
        int n;
        acc = accept(u);
        n = !acc ? 0 : sent < u.plen ? sent : u.plen;
        ok = acc && complete && !u.bad;
        chk({tag, ".beats"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk($sformatf("%s.data%0d", tag, i), 64'(got[i].d), 64'(pay[i]));
            chk($sformatf("%s.sop%0d", tag, i), 64'(got[i].sop), 64'(i == 0));
            chk($sformatf("%s.eop%0d", tag, i), 64'(got[i].eop), 64'(i == u.plen - 1));
            chk($sformatf("%s.chan%0d", tag, i), 64'(got[i].ch), 64'(u.dport - 16'd8080));
            chk($sformatf("%s.len%0d", tag, i), 64'(got[i].len), 64'(u.plen));
            if (i > 0) chk($sformatf("%s.gap%0d", tag, i), 64'(got[i].t - got[i-1].t), 64'd2);
        end
        chk({tag, ".stat_n"}, 64'(st_q.size()), 64'(acc));
        if (st_q.size() == 1) chk({tag, ".stat_ok"}, 64'(st_q[0]), 64'(ok));
        if (!ok && exp_drop < 65535) exp_drop++;
        chk({tag, ".cnt_drop"}, 64'(cnt_drop), 64'(exp_drop));
    endtask

    task automatic run_udp(input string tag, input udp_t u);
        rand_pay(u.plen);
        build_udp(u);
        drive(frm.size());
        stop(3);
        check_udp(tag, u, u.plen, 1'b1);
    endtask

    task automatic run_arp(input string tag, input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa, input bit bad);
        bit hit;
        hit = tpa == IP && !bad;
        build_arp(sha, spa, tpa, bad);
        drive(frm.size());
        stop(3);
        chk({tag, ".pulses"}, 64'(arp_n), 64'(hit));
        chk({tag, ".first_low"}, 64'(arp_first), 64'(hit));
        if (hit) begin
            exp_amac = sha;
            exp_aip = spa;
        end else exp_drop++;
        chk({tag, ".arp_mac"}, 64'(arp_mac), 64'(exp_amac));
        chk({tag, ".arp_ip"}, 64'(arp_ip), 64'(exp_aip));
        chk({tag, ".cnt_drop"}, 64'(cnt_drop), 64'(exp_drop));
    endtask

    initial begin
        udp_t u;
        #5 rst_n = 1'b0;
        repeat (3) @(posedge r_clk);
        #1;
        chk_zero("reset");
        @(negedge r_clk) rst_n = 1'b1;

        u = good();
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        build_udp(u);
        drive(frm.size());
        stop(3);
        check_udp("good8082", u, 5, 1'b1);

        u.bad = 1'b1;
        build_udp(u);
        drive(frm.size());
        stop(3);
        check_udp("badfcs", u, 5, 1'b1);

        u = good(); u.dport = 16'd8084;      run_udp("port8084", u);
        u = good(); u.dip = 32'hC0A80003;    run_udp("ip_dot3", u);
        u = good(); u.etype = 16'h86DD;      run_udp("ipv6", u);
        u = good(); u.frag = 16'h2000;       run_udp("mf", u);
        chk("drop_after_rejects", 64'(cnt_drop), 64'd5);

        run_arp("arp_hit", 48'h112233445566, 32'hC0A80009, IP, 1'b0);
        run_arp("arp_other", 48'h112233445566, 32'hC0A80009, 32'hC0A80007, 1'b0);
        run_arp("arp_badfcs", 48'hAABBCCDDEEFF, 32'hC0A80011, IP, 1'b1);

        u = good(); u.plen = 100; u.dport = 16'd8081;
        rand_pay(u.plen);
        build_udp(u);
        drive(42 + 40);
        nib(frm[82][3:0]);
        stop(3);
        check_udp("trunc", u, 40, 1'b0);
        u = good(); u.dport = 16'd8080; run_udp("after_trunc", u);

        u = good(); u.plen = 100; u.dport = 16'd8083;
        rand_pay(u.plen);
        build_udp(u);
        drive(42 + 20);
        @(posedge r_clk); #1;
        chk("pre_rst.valid", 64'(rx_valid), 64'd1);
        rst_n = 1'b0;
        r_dv = 1'b0;
        #1;
        chk_zero("mid_rst");
        exp_drop = 0; exp_amac = '0; exp_aip = '0;
        @(negedge r_clk) rst_n = 1'b1;
        u = good(); run_udp("post_rst", u);

        for (int n = 0; n < 30; n++) begin
            u = good();
            u.dport = 16'(16'd8080 + 16'($urandom_range(0, 3)));
            u.plen = int'($urandom_range(0, 24));
            u.frag = $urandom_range(0, 1) == 1 ? 16'h4000 : 16'h0000;
            case ($urandom_range(0, 9))
                0: u.dmac = {16'h0200, 32'($urandom)};
                1: u.dmac = '1;
                2: u.etype = 16'h86DD;
                3: u.vihl = 8'h46;
                4: u.frag = $urandom_range(0, 1) == 1 ? 16'h2000 : 16'h0005;
                5: u.proto = 8'd6;
                6: u.dip = 32'hC0A80003 + 32'($urandom_range(0, 5));
                7: u.dport = 16'(16'd8076 + 16'($urandom_range(0, 14)));
                8: u.bad = 1'b1;
                default: ;
            endcase
            run_udp($sformatf("rand%0d", n), u);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
